// File: rtl/ctrl_datapath.sv
// rtl/ctrl_datapath.sv - select-decoded capture/sum/double/finalize datapath
module ctrl_datapath #(
    parameter int size = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            e,
    input  logic            m,
    input  logic            s2,
    input  logic            s1,
    input  logic            s0,
    input  logic            done,
    input  logic [size-1:0] a,
    input  logic [size-1:0] b,
    output logic [size+1:0] result,
    output logic            valid,
    output logic            err,
    output logic [7:0]      opcount
);

    localparam logic [2:0] SEL_CAP = 3'b000;
    localparam logic [2:0] SEL_SUM = 3'b001;
    localparam logic [2:0] SEL_DBL = 3'b011;
    localparam logic [2:0] SEL_FIN = 3'b101;

    logic [size-1:0] r_ra;
    logic [size-1:0] r_rb;
    logic [size+1:0] r_acc;
    logic [size+1:0] r_result;
    logic            r_valid;
    logic            r_err;
    logic [7:0]      r_opcount;

    logic [2:0]      w_sel;
    logic            w_fin;
    logic [size+1:0] w_ra_ext;
    logic [size+1:0] w_rb_ext;

    assign w_sel    = {s2, s1, s0};
    assign w_fin    = e && done && (w_sel == SEL_FIN);
    assign w_ra_ext = {2'b00, r_ra};
    assign w_rb_ext = {2'b00, r_rb};

    // valid pulses for exactly the cycle following a qualifying finalize, regardless of e
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_fin;
        end
    end

    // enabled step decode; illegal selects only raise the sticky error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ra      <= '0;
            r_rb      <= '0;
            r_acc     <= '0;
            r_result  <= '0;
            r_err     <= 1'b0;
            r_opcount <= '0;
        end else if (e) begin
            case (w_sel)
                SEL_CAP: begin
                    r_ra  <= a;
                    r_rb  <= b;
                    r_acc <= '0;
                    r_err <= 1'b0;
                end
                SEL_SUM: begin
                    r_acc <= w_ra_ext + w_rb_ext;
                end
                SEL_DBL: begin
                    r_acc <= {r_acc[size:0], 1'b0};
                end
                SEL_FIN: begin
                    if (done) begin
                        r_result  <= m ? (r_acc - w_rb_ext) : r_acc;
                        r_opcount <= r_opcount + 8'd1;
                    end
                end
                default: begin
                    r_err <= 1'b1;
                end
            endcase
        end
    end

    assign result  = r_result;
    assign valid   = r_valid;
    assign err     = r_err;
    assign opcount = r_opcount;

endmodule

// File: tb/tb_ctrl_datapath.sv
// tb/tb_ctrl_datapath.sv - scoreboard bench for ctrl_datapath
module tb_ctrl_datapath;

    logic       clk;
    logic       reset;
    logic       e;
    logic       m;
    logic       s2;
    logic       s1;
    logic       s0;
    logic       done;
    logic [3:0] a;
    logic [3:0] b;
    logic [5:0] result;
    logic       valid;
    logic       err;
    logic [7:0] opcount;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_opc;
    logic [13:0] q[$];

    ctrl_datapath #(.size(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .e      (e),
        .m      (m),
        .s2     (s2),
        .s1     (s1),
        .s0     (s0),
        .done   (done),
        .a      (a),
        .b      (b),
        .result (result),
        .valid  (valid),
        .err    (err),
        .opcount(opcount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step(input logic [2:0] sel, input logic en, input logic dn,
                        input logic mm, input logic [3:0] aa, input logic [3:0] bb);
        e = en;
        {s2, s1, s0} = sel;
        done = dn;
        m = mm;
        a = aa;
        b = bb;
        @(posedge clk);
        #1;
    endtask

    task automatic cap(input logic [3:0] aa, input logic [3:0] bb);
        step(3'b000, 1'b1, 1'b0, 1'b0, aa, bb);
    endtask

    task automatic op(input logic [2:0] sel);
        step(sel, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    endtask

    task automatic fin(input logic mm, input logic [5:0] exp_res);
        exp_opc = exp_opc + 8'd1;
        q.push_back({exp_res, exp_opc});
        step(3'b101, 1'b1, 1'b1, mm, 4'd0, 4'd0);
    endtask

    // monitor: every valid cycle must match the oldest outstanding finalize
    always @(negedge clk) begin
        if (valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid actual=1 expected=0 result=%0d", result);
            end else begin
                logic [13:0] ent;
                ent = q.pop_front();
                chk("result", {26'd0, result}, {26'd0, ent[13:8]});
                chk("opcount", {24'd0, opcount}, {24'd0, ent[7:0]});
            end
        end
    end

    initial begin
        exp_opc = 8'd0;
        reset = 1'b1;
        e = 1'b0;
        m = 1'b0;
        {s2, s1, s0} = 3'b000;
        done = 1'b0;
        a = 4'd0;
        b = 4'd0;
        #12;
        chk("reset_result", {26'd0, result}, 32'd0);
        chk("reset_valid", {31'd0, valid}, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        chk("reset_opcount", {24'd0, opcount}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 5,3 pass and subtract
        cap(4'd5, 4'd3); op(3'b001); op(3'b011); fin(1'b0, 6'd16);
        cap(4'd5, 4'd3); op(3'b001); op(3'b011); fin(1'b1, 6'd13);

        // full-scale operands, back-to-back finalizes
        cap(4'd15, 4'd15); op(3'b001); op(3'b011); fin(1'b0, 6'd60); fin(1'b1, 6'd45);

        // second double drops the MSB: 120 mod 64
        cap(4'd15, 4'd15); op(3'b001); op(3'b011); op(3'b011); fin(1'b0, 6'd56);

        // subtraction wraps when acc < rb
        cap(4'd0, 4'd3); fin(1'b1, 6'd61);

        // illegal select holds acc, err sticky until capture
        cap(4'd5, 4'd3); op(3'b001); op(3'b110);
        chk("err_set_110", {31'd0, err}, 32'd1);
        step(3'b011, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        step(3'b001, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
        chk("err_sticky", {31'd0, err}, 32'd1);
        fin(1'b0, 6'd8);
        cap(4'd1, 4'd1);
        chk("err_cleared", {31'd0, err}, 32'd0);
        step(3'b111, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        chk("err_disabled_111", {31'd0, err}, 32'd0);
        op(3'b010);
        chk("err_set_010", {31'd0, err}, 32'd1);
        cap(4'd1, 4'd1);
        op(3'b100);
        chk("err_set_100", {31'd0, err}, 32'd1);

        // e=0 full sequence changes nothing; done=0 finalize is ignored
        cap(4'd7, 4'd2); op(3'b001);
        step(3'b000, 1'b0, 1'b0, 1'b0, 4'd15, 4'd15);
        step(3'b001, 1'b0, 1'b0, 1'b0, 4'd15, 4'd15);
        step(3'b011, 1'b0, 1'b0, 1'b0, 4'd15, 4'd15);
        step(3'b101, 1'b0, 1'b1, 1'b1, 4'd15, 4'd15);
        chk("hold_result", {26'd0, result}, 32'd8);
        chk("hold_valid", {31'd0, valid}, 32'd0);
        step(3'b101, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0);
        chk("nodone_valid", {31'd0, valid}, 32'd0);
        chk("nodone_opcount", {24'd0, opcount}, {24'd0, exp_opc});
        fin(1'b1, 6'd7);

        // asynchronous reset between sum and double
        cap(4'd5, 4'd3); op(3'b001); op(3'b110);
        #1;
        reset = 1'b1;
        #1;
        chk("async_result", {26'd0, result}, 32'd0);
        chk("async_opcount", {24'd0, opcount}, 32'd0);
        chk("async_err", {31'd0, err}, 32'd0);
        chk("async_valid", {31'd0, valid}, 32'd0);
        exp_opc = 8'd0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        op(3'b011); fin(1'b0, 6'd0);

        // opcount wraps after 256 finalizes
        for (int i = 0; i < 255; i++) begin
            fin(1'b0, 6'd0);
        end
        chk("opcount_wrap", {24'd0, opcount}, 32'd0);

        op(3'b001); op(3'b001);
        chk("scoreboard_drained", q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
